// File: rtl/uart_glue_pkg.sv
// Shared types and helpers for the board-side UART/reset glue.
package uart_glue_pkg;

  // SoC reset sequencing: HOLD keeps the SoC in reset, RUN releases it.
  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } glue_state_e;

  // reset_cause encodings reported to the SoC.
  localparam logic [1:0] CAUSE_EXT   = 2'b01;
  localparam logic [1:0] CAUSE_BREAK = 2'b10;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rx_conditioner.sv
// One RX channel: metastability synchroniser followed by a persistence filter
// that only follows a new level once it has been stable for FILT_CYCLES.
module uart_rx_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_async_i,
  output logic rx_filt_o
);
  import uart_glue_pkg::*;

  localparam int CntW = cnt_width(FILT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt_q, filt_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign rx_filt_o = filt_q;

  // Shift the raw pin through the synchroniser chain; idle-high after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_async_i};
    end
  end

  // Count consecutive disagreeing samples; flip the output on the last one.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (synced != filt_q) begin
      if (cnt_q == CntW'(FILT_CYCLES - 1)) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_board_glue.sv
// FPGA-top glue between board pins and the SoC: conditioned RX, registered TX,
// power-on reset stretching and a UART-break-triggered SoC reset on channel 0.
module uart_board_glue #(
  parameter int NUM_UART        = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int FILT_CYCLES     = 4,
  parameter int BREAK_CYCLES    = 2083,
  parameter int POR_CYCLES      = 1024,
  parameter int RST_HOLD_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_UART-1:0] uart_rx_pin,
  output logic [NUM_UART-1:0] uart_tx_pin,
  input  logic [NUM_UART-1:0] soc_uart_tx,
  output logic [NUM_UART-1:0] soc_uart_rx,
  input  logic                break_reset_en,
  output logic                soc_reset,
  output logic [1:0]          reset_cause
);
  import uart_glue_pkg::*;

  localparam int BrkW    = cnt_width(BREAK_CYCLES);
  localparam int HoldMax = (POR_CYCLES > RST_HOLD_CYCLES) ? POR_CYCLES : RST_HOLD_CYCLES;
  localparam int HoldW   = cnt_width(HoldMax);

  for (genvar ch = 0; ch < NUM_UART; ch++) begin : g_rx
    uart_rx_conditioner #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_cond (
      .clk       (clk),
      .reset     (reset),
      .rx_async_i(uart_rx_pin[ch]),
      .rx_filt_o (soc_uart_rx[ch])
    );
  end

  logic [BrkW-1:0]     brkCnt_q, brkCnt_d;
  logic                armed_q, armed_d;
  logic                breakTrig;
  glue_state_e         state_q, state_d;
  logic [HoldW-1:0]    holdCnt_q, holdCnt_d;
  logic [1:0]          cause_q, cause_d;
  logic                socReset_q, socReset_d;
  logic [NUM_UART-1:0] tx_q, tx_d;

  assign soc_reset   = socReset_q;
  assign reset_cause = cause_q;
  assign uart_tx_pin = tx_q;

  // Break detector: measure the filtered-low run on channel 0, fire once per break.
  always_comb begin
    brkCnt_d  = brkCnt_q;
    armed_d   = armed_q;
    breakTrig = 1'b0;
    if (soc_uart_rx[0]) begin
      brkCnt_d = '0;
      armed_d  = 1'b1;
    end else if (brkCnt_q != BrkW'(BREAK_CYCLES)) begin
      brkCnt_d = brkCnt_q + 1'b1;
      if ((brkCnt_d == BrkW'(BREAK_CYCLES)) && armed_q && break_reset_en) begin
        breakTrig = 1'b1;
        armed_d   = 1'b0;
      end
    end
  end

  // Reset sequencer: count down in HOLD, re-enter HOLD on a break from RUN.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    cause_d   = cause_q;
    case (state_q)
      HOLD: begin
        holdCnt_d = holdCnt_q - 1'b1;
        if (holdCnt_q == HoldW'(1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (breakTrig) begin
          state_d   = HOLD;
          holdCnt_d = HoldW'(RST_HOLD_CYCLES);
          cause_d   = CAUSE_BREAK;
        end
      end
      default: state_d = HOLD;
    endcase
    socReset_d = (state_d == HOLD);
    tx_d       = socReset_d ? {NUM_UART{1'b1}} : soc_uart_tx;
  end

  // Registers for the break detector, reset sequencer and TX pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      brkCnt_q   <= '0;
      armed_q    <= 1'b1;
      state_q    <= HOLD;
      holdCnt_q  <= HoldW'(POR_CYCLES);
      cause_q    <= CAUSE_EXT;
      socReset_q <= 1'b1;
      tx_q       <= '1;
    end else begin
      brkCnt_q   <= brkCnt_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      holdCnt_q  <= holdCnt_d;
      cause_q    <= cause_d;
      socReset_q <= socReset_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_board_glue.sv
// Self-checking bench for uart_board_glue: directed vector table, hand-written
// latency/glitch sequences and a randomized run against a behavioural model.
module tb_uart_board_glue;

  localparam int NUM   = 2;
  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int BRK   = 20;
  localparam int POR   = 8;
  localparam int RHOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rxPin;
  logic [1:0] txPin;
  logic [1:0] socTx;
  logic [1:0] socRx;
  logic       breakEn;
  logic       socReset;
  logic [1:0] cause;

  int checksTotal  = 0;
  int checksPassed = 0;

  typedef struct {
    logic       rst;
    logic [1:0] rx;
    logic [1:0] tx;
    logic       en;
    int         cycles;
    logic       expSoc;
    logic [1:0] expCause;
    logic [1:0] expTx;
    logic [1:0] expRx;
  } vec_t;

  vec_t vecs[25];

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  uart_board_glue #(
    .NUM_UART       (NUM),
    .SYNC_STAGES    (SYNC),
    .FILT_CYCLES    (FILT),
    .BREAK_CYCLES   (BRK),
    .POR_CYCLES     (POR),
    .RST_HOLD_CYCLES(RHOLD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx_pin   (rxPin),
    .uart_tx_pin   (txPin),
    .soc_uart_tx   (socTx),
    .soc_uart_rx   (socRx),
    .break_reset_en(breakEn),
    .soc_reset     (socReset),
    .reset_cause   (cause)
  );

  // One comparison: bumps the counters and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drives one table row for its cycle count, then compares the row's expectations.
  task automatic applyStimulus(input vec_t v, input int idx);
    reset   = v.rst;
    rxPin   = v.rx;
    socTx   = v.tx;
    breakEn = v.en;
    repeat (v.cycles) @(negedge clk);
    checkOutput($sformatf("row%0d soc_reset", idx), 32'(socReset), 32'(v.expSoc));
    checkOutput($sformatf("row%0d reset_cause", idx), 32'(cause), 32'(v.expCause));
    checkOutput($sformatf("row%0d uart_tx_pin", idx), 32'(txPin), 32'(v.expTx));
    checkOutput($sformatf("row%0d soc_uart_rx", idx), 32'(socRx), 32'(v.expRx));
  endtask

  // Behavioural model state: pin history, recent synced samples, break run length.
  bit         modelOn = 1'b0;
  logic [1:0] pinQ[$];
  logic [1:0] winQ[$];
  logic [1:0] filtM, txM, causeM, syncedM;
  int         holdM, runM;
  bit         trigM, allDiff;

  // Model advances on every clock edge from the same inputs the DUT sees.
  always @(posedge clk) begin
    if (reset) begin
      pinQ = {};
      winQ = {};
      for (int i = 0; i < SYNC; i++) pinQ.push_back(2'b11);
      for (int i = 0; i < FILT; i++) winQ.push_back(2'b11);
      filtM   = 2'b11;
      txM     = 2'b11;
      causeM  = 2'b01;
      holdM   = POR;
      runM    = 0;
      modelOn = 1'b1;
    end else if (modelOn) begin
      trigM = !filtM[0] && (runM + 1 == BRK) && breakEn;
      runM  = filtM[0] ? 0 : runM + 1;
      if (holdM > 0) holdM--;
      else if (trigM) begin
        holdM  = RHOLD;
        causeM = 2'b10;
      end
      txM = (holdM > 0) ? 2'b11 : socTx;
      syncedM = pinQ.pop_front();
      pinQ.push_back(rxPin);
      winQ.push_back(syncedM);
      void'(winQ.pop_front());
      for (int c = 0; c < NUM; c++) begin
        allDiff = 1'b1;
        foreach (winQ[k]) if (winQ[k][c] == filtM[c]) allDiff = 1'b0;
        if (allDiff) filtM[c] = ~filtM[c];
      end
    end
  end

  // Compare every output against the model once it has seen a reset.
  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("model soc_reset", 32'(socReset), 32'(holdM > 0));
      checkOutput("model reset_cause", 32'(cause), 32'(causeM));
      checkOutput("model uart_tx_pin", 32'(txPin), 32'(txM));
      checkOutput("model soc_uart_rx", 32'(socRx), 32'(filtM));
    end
  end

  // Main sequence: POR, glitch filter, vector table, then randomized traffic.
  initial begin
    int dur[2];

    vecs[0]  = '{1'b1, 2'b11, 2'b00, 1'b1,  3, 1'b1, 2'b01, 2'b11, 2'b11};
    vecs[1]  = '{1'b0, 2'b11, 2'b00, 1'b1,  7, 1'b1, 2'b01, 2'b11, 2'b11};
    vecs[2]  = '{1'b0, 2'b11, 2'b00, 1'b1,  1, 1'b0, 2'b01, 2'b00, 2'b11};
    vecs[3]  = '{1'b0, 2'b11, 2'b10, 1'b1,  2, 1'b0, 2'b01, 2'b10, 2'b11};
    vecs[4]  = '{1'b0, 2'b10, 2'b00, 1'b1, 25, 1'b1, 2'b10, 2'b11, 2'b10};
    vecs[5]  = '{1'b0, 2'b10, 2'b00, 1'b1,  3, 1'b1, 2'b10, 2'b11, 2'b10};
    vecs[6]  = '{1'b0, 2'b10, 2'b00, 1'b1,  1, 1'b0, 2'b10, 2'b00, 2'b10};
    vecs[7]  = '{1'b0, 2'b10, 2'b00, 1'b1, 11, 1'b0, 2'b10, 2'b00, 2'b10};
    vecs[8]  = '{1'b0, 2'b11, 2'b00, 1'b1,  8, 1'b0, 2'b10, 2'b00, 2'b11};
    vecs[9]  = '{1'b0, 2'b10, 2'b00, 1'b1, 25, 1'b1, 2'b10, 2'b11, 2'b10};
    vecs[10] = '{1'b0, 2'b10, 2'b00, 1'b1,  4, 1'b0, 2'b10, 2'b00, 2'b10};
    vecs[11] = '{1'b0, 2'b10, 2'b00, 1'b1, 11, 1'b0, 2'b10, 2'b00, 2'b10};
    vecs[12] = '{1'b0, 2'b11, 2'b00, 1'b1,  8, 1'b0, 2'b10, 2'b00, 2'b11};
    vecs[13] = '{1'b1, 2'b11, 2'b00, 1'b0,  2, 1'b1, 2'b01, 2'b11, 2'b11};
    vecs[14] = '{1'b0, 2'b11, 2'b00, 1'b0, 10, 1'b0, 2'b01, 2'b00, 2'b11};
    vecs[15] = '{1'b0, 2'b10, 2'b00, 1'b0, 30, 1'b0, 2'b01, 2'b00, 2'b10};
    vecs[16] = '{1'b0, 2'b10, 2'b00, 1'b1, 10, 1'b0, 2'b01, 2'b00, 2'b10};
    vecs[17] = '{1'b0, 2'b11, 2'b00, 1'b1,  8, 1'b0, 2'b01, 2'b00, 2'b11};
    vecs[18] = '{1'b0, 2'b01, 2'b01, 1'b1, 40, 1'b0, 2'b01, 2'b01, 2'b01};
    vecs[19] = '{1'b0, 2'b11, 2'b00, 1'b1,  8, 1'b0, 2'b01, 2'b00, 2'b11};
    vecs[20] = '{1'b0, 2'b10, 2'b00, 1'b1, 26, 1'b1, 2'b10, 2'b11, 2'b10};
    vecs[21] = '{1'b1, 2'b11, 2'b00, 1'b1,  2, 1'b1, 2'b01, 2'b11, 2'b11};
    vecs[22] = '{1'b0, 2'b11, 2'b00, 1'b1,  7, 1'b1, 2'b01, 2'b11, 2'b11};
    vecs[23] = '{1'b0, 2'b11, 2'b00, 1'b1,  1, 1'b0, 2'b01, 2'b00, 2'b11};
    vecs[24] = '{1'b0, 2'b10, 2'b00, 1'b1, 25, 1'b1, 2'b10, 2'b11, 2'b10};

    reset   = 1'b1;
    rxPin   = 2'b11;
    socTx   = 2'b00;
    breakEn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset soc_reset", 32'(socReset), 32'd1);
    checkOutput("reset reset_cause", 32'(cause), 32'h1);
    checkOutput("reset uart_tx_pin", 32'(txPin), 32'h3);
    checkOutput("reset soc_uart_rx", 32'(socRx), 32'h3);

    $display("[TB] power-on reset stretch");
    reset = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      checkOutput($sformatf("por soc_reset c%0d", k), 32'(socReset), 32'(k < POR));
      checkOutput($sformatf("por uart_tx_pin c%0d", k), 32'(txPin), (k < POR) ? 32'h3 : 32'h0);
      @(negedge clk);
    end

    $display("[TB] glitch filter");
    rxPin[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("glitch2 rx0 c%0d", k), 32'(socRx[0]), 32'd1);
      if (k == 2) rxPin[0] = 1'b1;
    end
    rxPin[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checkOutput($sformatf("pulse3 rx0 c%0d", k), 32'(socRx[0]), 32'(!(k >= 5 && k <= 7)));
      if (k == 3) rxPin[0] = 1'b1;
    end

    $display("[TB] directed vector table");
    for (int i = 0; i < 25; i++) applyStimulus(vecs[i], i);

    $display("[TB] randomized traffic");
    dur[0] = 0;
    dur[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NUM; c++) begin
        if (dur[c] == 0) begin
          rxPin[c] = ~rxPin[c];
          dur[c]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45))
                                                 : int'($urandom_range(1, 6));
        end
        dur[c]--;
      end
      socTx = 2'($urandom);
      if ($urandom_range(0, 60) == 0) breakEn = ~breakEn;
      reset = ($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/uart_board_glue.md
Name: uart_board_glue

Overview:
- Board-facing conditioning block between the FPGA pins and the SoC's CLK/RST_N and UART ports, sitting alongside the SoC instance in the FPGA top level.
- Generalises the plain pin-to-SoC wiring:
  - N UART channels, each with an RX synchroniser and glitch filter.
  - Registered TX pins, held idle while the SoC is in reset.
  - A power-on reset stretcher.
  - A UART-break-triggered SoC reset on channel 0, for debug recovery without pressing the board button.

Parameters:
- NUM_UART, 1, number of UART channels
- SYNC_STAGES, 2, RX synchroniser flops per channel (min 2)
- FILT_CYCLES, 4, consecutive cycles a new synced level must persist before the filtered output follows (min 1)
- BREAK_CYCLES, 2083, filtered-low cycles on channel 0 that qualify as a break (> FILT_CYCLES; default is about 20 bit times at 12 MHz / 115200)
- POR_CYCLES, 1024, SoC reset hold after external reset release (min 1)
- RST_HOLD_CYCLES, 64, SoC reset hold after a break trigger (min 1)

Ports:
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high; dominates all other inputs
- uart_rx_pin  in  NUM_UART  asynchronous RX from board pins
- uart_tx_pin  out  NUM_UART  registered TX to board pins
- soc_uart_tx  in  NUM_UART  TX from SoC
- soc_uart_rx  out  NUM_UART  conditioned RX to SoC
- break_reset_en  in  1  enables break-triggered SoC reset; sampled each cycle
- soc_reset  out  1  active-high reset to the SoC; registered
- reset_cause  out  2  01 = external/POR, 10 = break; 00 and 11 unused

Behaviour:
- Interface decided: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - All synchroniser flops, filtered RX outputs and uart_tx_pin: 1 (line idle).
  - soc_reset: 1; reset_cause: 01.
  - FSM: HOLD, with hold counter = POR_CYCLES; break counter: 0; break armed: 1.
- RX path, per channel:
  - SYNC_STAGES-flop synchroniser feeding the filter.
  - Filter counter counts while synced value differs from the filtered value and clears when they are equal.
  - When the counter reaches FILT_CYCLES, the filtered value toggles and the counter clears.
  - Pin-to-soc_uart_rx latency is SYNC_STAGES + FILT_CYCLES cycles.
  - Pulses shorter than FILT_CYCLES are rejected.
- TX path:
  - uart_tx_pin is the registered soc_uart_tx, with 1-cycle latency.
  - uart_tx_pin is forced to 1 whenever soc_reset is 1.
- Break detector, channel 0 filtered RX only:
  - Counter increments while the filtered value is 0, saturates at BREAK_CYCLES, and clears when it is 1.
  - Trigger fires for one cycle when the counter first reaches BREAK_CYCLES, the detector is armed, and break_reset_en is 1.
  - The trigger disarms the detector; it re-arms when filtered RX returns to 1. One trigger per break regardless of duration.
  - If break_reset_en is 0 when the count is reached, there is no trigger and the detector stays armed but saturated; no late trigger if break_reset_en rises later in the same break.
- Reset FSM, states HOLD and RUN:
  - HOLD: soc_reset = 1; counter decrements each cycle. On the cycle it reaches 0 → RUN.
  - RUN: soc_reset = 0.
  - First cycle with reset low is cycle 0; soc_reset reads 0 from cycle POR_CYCLES onward.
  - Trigger in RUN → HOLD, counter = RST_HOLD_CYCLES, reset_cause = 10. soc_reset rises the cycle after the trigger and stays high for exactly RST_HOLD_CYCLES cycles.
  - Trigger in HOLD: ignored; the counter is not reloaded.
- Filters and the break detector are cleared only by `reset`, not by soc_reset.
- reset_cause holds its value until the next reset or break event.
- Counter widths are $clog2(max+1) of their limits; no wrap-around is possible.

Decomposition:
- Package `uart_glue_pkg`:
  - FSM state enum {HOLD, RUN}.
  - reset_cause encodings CAUSE_EXT = 2'b01, CAUSE_BREAK = 2'b10.
  - Helper for counter widths.
- Sub-module `uart_rx_conditioner`: synchroniser plus filter, parameters SYNC_STAGES and FILT_CYCLES, instantiated NUM_UART times.
- The break detector and FSM live in the top module.

Test Plan (overrides: NUM_UART = 2, SYNC_STAGES = 2, FILT_CYCLES = 3, BREAK_CYCLES = 20, POR_CYCLES = 8, RST_HOLD_CYCLES = 4):
- POR: reset high for 3 cycles then low → soc_reset = 1 for cycles 0–7 and 0 from cycle 8; reset_cause = 01; uart_tx_pin = 2'b11 throughout HOLD even with soc_uart_tx = 2'b00.
- Glitch filter:
  - 2-cycle low pulse on rx_pin[0] → soc_uart_rx[0] stays 1.
  - 3-cycle low pulse → soc_uart_rx[0] falls 5 cycles after the pin edge and is low for 3 cycles.
- Break, break_reset_en = 1, rx_pin[0] low for 40 cycles:
  - Exactly one soc_reset pulse of 4 cycles; reset_cause = 10; TX pins forced to 1 during the pulse.
  - Release, then a second 40-cycle low → second pulse.
- break_reset_en = 0, same 40-cycle break → soc_reset stays 0, reset_cause stays 01. Raising break_reset_en mid-break produces no trigger.
- 40-cycle low on rx_pin[1] only → no SoC reset; soc_uart_rx[1] follows with 5-cycle latency.
- Assert reset during a break hold → FSM reloads POR_CYCLES; soc_reset low at cycle 8 after release; reset_cause = 01; break detector re-armed.
